rnn_sequencer: RTL
==================

Name: rnn_sequencer

Overview:
- Frame-level controller for the denoise RNN datapath (dense1, gru1, dense2, gru2, gru3, dense3).
- Issues one-cycle start pulses and waits on each unit's valid.
- Generates the write strobes for the recurrent-state registers; overlaps dense2 with gru2, which need the same operands.
- Adds per-phase timeout, a state-clear path, a frame counter and a done pulse. Replaces the level-based start chain in the RNN top.

Parameters:
TIMEOUT, 4095, max cycles waiting in any phase; 0 disables timeout
TO_W, 12, timeout counter width (must hold TIMEOUT)
FRAME_W, 16, frame counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  frame request, sampled only in IDLE
clear_state  in  1  sampled with accepted start; zero all GRU states before the frame
valid_dense1, valid_gru1, valid_dense2, valid_gru2, valid_gru3, valid_dense3  in  1 each  unit completion
start_dense1, start_gru1, start_dense2, start_gru2, start_gru3, start_dense3  out  1 each  one-cycle unit start pulses
state_clr  out  1  one-cycle pulse: zero vad/noise/denoise state regs
vad_state_we, noise_state_we, denoise_state_we  out  1 each  one-cycle state register load strobes
vad_we  out  1  one-cycle strobe: capture vad output
busy  out  1  high from cycle after accepted start until done/err
done  out  1  one-cycle pulse, gains valid
err  out  1  one-cycle pulse on timeout
err_unit  out  3  unit that timed out (1=dense1, 2=gru1, 3=dense2, 4=gru2, 5=gru3, 6=dense3, 0=none); held until next accepted start
frame_cnt  out  FRAME_W  completed frames, wraps

Behaviour:
- Reset (async, rst_n low): all outputs 0, FSM=IDLE, counters 0. Reset mid-frame aborts immediately. No pulse is emitted on release.
- States: IDLE, CLR, D1, G1, WB1, PAR, WB2, G3, WB3, D3, FIN.
- IDLE: start=1 -> CLR if clear_state else D1. busy=1 and err_unit=0 from the next cycle. Start is ignored in every other state (no queuing).
- CLR: state_clr=1 for one cycle -> D1.
- D1 entry cycle: start_dense1=1 for one cycle. Wait for valid_dense1 -> G1. Each wait state pulses its unit's start in its first cycle.
- G1: pulse start_gru1; on valid_gru1 -> WB1.
- WB1: vad_state_we=1 for one cycle -> PAR. Downstream starts come a cycle after the load so units see the updated register.
- PAR: pulse start_dense2 and start_gru2 in the same first cycle.
  - Track two done flags; valids may arrive in either order or the same cycle.
  - vad_we pulses the cycle after valid_dense2 is seen.
  - When both flags set -> WB2.
- WB2: noise_state_we for one cycle -> G3.
- G3: pulse start_gru3; on valid_gru3 -> WB3.
- WB3: denoise_state_we for one cycle -> D3.
- D3: pulse start_dense3; on valid_dense3 -> FIN.
- FIN (one cycle): done=1, busy=0, frame_cnt+1 (all-ones wraps to 0) -> IDLE. Latency from valid_dense3 to done is 1 cycle.
- Valid from a unit not currently awaited is ignored. In PAR, a repeated valid from an already-flagged unit is ignored.
- Timeout:
  - Phase counter clears on entry to each wait state (D1, G1, PAR, G3, D3) and increments each cycle waiting.
  - Reaching TIMEOUT without the awaited valid -> err=1 for one cycle, err_unit set, busy=0, -> IDLE. No state_we, no done.
  - In PAR, err_unit reports dense2 if its flag is missing, else gru2.
  - A valid arriving in the same cycle the counter hits TIMEOUT wins (no error).
- At most one start_* output is high per cycle, except start_dense2+start_gru2 in PAR.

Test Plan:
- Reset, start=1 with clear_state=0; all unit valids return 3 cycles after their start -> start_dense1 1 cycle after start accepted, then G1, WB1, PAR, WB2, G3, WB3, D3, FIN each in order; each start and each state_we is exactly 1 cycle wide; done once; frame_cnt=1.
- start with clear_state=1 -> state_clr pulse in the cycle before start_dense1; otherwise identical sequence.
- PAR ordering: valid_gru2 at +2 then valid_dense2 at +7; repeat with order reversed; repeat with both same cycle -> noise_state_we exactly once, 1 cycle after the later valid; vad_we 1 cycle after valid_dense2 in all cases.
- TIMEOUT=8, valid_gru3 withheld -> err pulse 8 cycles after G3 entry, err_unit=5, no denoise_state_we, no done, frame_cnt unchanged. Then a new start -> err_unit=0 and a normal frame.
- Start pulses and spurious valid_dense3 during G1 -> ignored; exactly one frame completes. rst_n low mid-PAR -> all outputs 0 asynchronously; next start runs a clean frame.
- FRAME_W=2, run 5 frames -> frame_cnt 1,2,3,0,1.

Source files
------------

// File: rtl/rnn_sequencer.sv
// Frame-level controller for the denoise RNN datapath.
// Sequences dense1 -> gru1 -> (dense2 || gru2) -> gru3 -> dense3 with one-cycle
// start pulses, recurrent-state write strobes, per-phase timeout and a frame counter.
module rnn_sequencer #(
  parameter int unsigned TIMEOUT = 4095,
  parameter int unsigned TO_W    = 12,
  parameter int unsigned FRAME_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear_state,
  input  logic               valid_dense1,
  input  logic               valid_gru1,
  input  logic               valid_dense2,
  input  logic               valid_gru2,
  input  logic               valid_gru3,
  input  logic               valid_dense3,
  output logic               start_dense1,
  output logic               start_gru1,
  output logic               start_dense2,
  output logic               start_gru2,
  output logic               start_gru3,
  output logic               start_dense3,
  output logic               state_clr,
  output logic               vad_state_we,
  output logic               noise_state_we,
  output logic               denoise_state_we,
  output logic               vad_we,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         err_unit,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam logic [2:0] UNIT_D1 = 3'd1;
  localparam logic [2:0] UNIT_G1 = 3'd2;
  localparam logic [2:0] UNIT_D2 = 3'd3;
  localparam logic [2:0] UNIT_G2 = 3'd4;
  localparam logic [2:0] UNIT_G3 = 3'd5;
  localparam logic [2:0] UNIT_D3 = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_D1, S_G1, S_WB1, S_PAR, S_WB2, S_G3, S_WB3, S_D3, S_FIN
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              d2_q, d2_d;
  logic              g2_q, g2_d;
  logic              timeout_c;

  logic              start_dense1_d, start_gru1_d, start_dense2_d;
  logic              start_gru2_d, start_gru3_d, start_dense3_d;
  logic              state_clr_d, vad_state_we_d, noise_state_we_d;
  logic              denoise_state_we_d, vad_we_d, busy_d, done_d, err_d;
  logic [2:0]        err_unit_d;
  logic [FRAME_W-1:0] frame_cnt_d;

  // State, phase counter, PAR flags and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      d2_q             <= 1'b0;
      g2_q             <= 1'b0;
      start_dense1     <= 1'b0;
      start_gru1       <= 1'b0;
      start_dense2     <= 1'b0;
      start_gru2       <= 1'b0;
      start_gru3       <= 1'b0;
      start_dense3     <= 1'b0;
      state_clr        <= 1'b0;
      vad_state_we     <= 1'b0;
      noise_state_we   <= 1'b0;
      denoise_state_we <= 1'b0;
      vad_we           <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      err_unit         <= '0;
      frame_cnt        <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      d2_q             <= d2_d;
      g2_q             <= g2_d;
      start_dense1     <= start_dense1_d;
      start_gru1       <= start_gru1_d;
      start_dense2     <= start_dense2_d;
      start_gru2       <= start_gru2_d;
      start_gru3       <= start_gru3_d;
      start_dense3     <= start_dense3_d;
      state_clr        <= state_clr_d;
      vad_state_we     <= vad_state_we_d;
      noise_state_we   <= noise_state_we_d;
      denoise_state_we <= denoise_state_we_d;
      vad_we           <= vad_we_d;
      busy             <= busy_d;
      done             <= done_d;
      err              <= err_d;
      err_unit         <= err_unit_d;
      frame_cnt        <= frame_cnt_d;
    end
  end

  // Phase has waited TIMEOUT cycles once this edge is taken without a valid.
  assign timeout_c = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT - 1));

  // Next state plus next values of outputs; entry pulses derive from the transition.
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q + TO_W'(1);
    d2_d               = d2_q;
    g2_d               = g2_q;
    start_dense1_d     = 1'b0;
    start_gru1_d       = 1'b0;
    start_dense2_d     = 1'b0;
    start_gru2_d       = 1'b0;
    start_gru3_d       = 1'b0;
    start_dense3_d     = 1'b0;
    state_clr_d        = 1'b0;
    vad_state_we_d     = 1'b0;
    noise_state_we_d   = 1'b0;
    denoise_state_we_d = 1'b0;
    vad_we_d           = 1'b0;
    done_d             = 1'b0;
    err_d              = 1'b0;
    err_unit_d         = err_unit;
    frame_cnt_d        = frame_cnt;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = clear_state ? S_CLR : S_D1;
          err_unit_d = '0;
        end
      end
      S_CLR: state_d = S_D1;
      S_D1: begin
        if (valid_dense1) begin
          state_d = S_G1;
        end else if (timeout_c) begin
          state_d    = S_IDLE;
          err_d      = 1'b1;
          err_unit_d = UNIT_D1;
        end
      end
      S_G1: begin
        if (valid_gru1) begin
          state_d = S_WB1;
        end else if (timeout_c) begin
          state_d    = S_IDLE;
          err_d      = 1'b1;
          err_unit_d = UNIT_G1;
        end
      end
      S_WB1: state_d = S_PAR;
      S_PAR: begin
        d2_d     = d2_q | valid_dense2;
        g2_d     = g2_q | valid_gru2;
        vad_we_d = valid_dense2 & ~d2_q;
        if (d2_d && g2_d) begin
          state_d = S_WB2;
        end else if (timeout_c) begin
          state_d    = S_IDLE;
          err_d      = 1'b1;
          err_unit_d = d2_d ? UNIT_G2 : UNIT_D2;
        end
      end
      S_WB2: state_d = S_G3;
      S_G3: begin
        if (valid_gru3) begin
          state_d = S_WB3;
        end else if (timeout_c) begin
          state_d    = S_IDLE;
          err_d      = 1'b1;
          err_unit_d = UNIT_G3;
        end
      end
      S_WB3: state_d = S_D3;
      S_D3: begin
        if (valid_dense3) begin
          state_d = S_FIN;
        end else if (timeout_c) begin
          state_d    = S_IDLE;
          err_d      = 1'b1;
          err_unit_d = UNIT_D3;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      case (state_d)
        S_CLR: state_clr_d = 1'b1;
        S_D1: begin
          start_dense1_d = 1'b1;
          cnt_d          = '0;
        end
        S_G1: begin
          start_gru1_d = 1'b1;
          cnt_d        = '0;
        end
        S_WB1: vad_state_we_d = 1'b1;
        S_PAR: begin
          start_dense2_d = 1'b1;
          start_gru2_d   = 1'b1;
          cnt_d          = '0;
          d2_d           = 1'b0;
          g2_d           = 1'b0;
        end
        S_WB2: noise_state_we_d = 1'b1;
        S_G3: begin
          start_gru3_d = 1'b1;
          cnt_d        = '0;
        end
        S_WB3: denoise_state_we_d = 1'b1;
        S_D3: begin
          start_dense3_d = 1'b1;
          cnt_d          = '0;
        end
        S_FIN: begin
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt + FRAME_W'(1);
        end
        default: ;
      endcase
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
  end

endmodule
